// File: rtl/rolling_average_calc_if.sv
// Sample-window handshake between the upstream tap shift register and the averager.
// The master side supplies the start pulse and tap bus; the slave side returns results.
interface rolling_average_calc_if #(
    parameter int TOTAL_TAPS    = 8,
    parameter int BITS_PER_ELEM = 5,
    parameter int TOTAL_BITS    = 40
);
    localparam int SUM_BITS = BITS_PER_ELEM + $clog2(TOTAL_TAPS);

    logic                            i_start_calc;
    logic [TOTAL_BITS-1:0]           i_taps;
    logic signed [SUM_BITS-1:0]      o_sum;
    logic signed [BITS_PER_ELEM-1:0] o_average;
    logic                            o_valid;
    logic                            o_busy;
    logic                            o_overrun;

    modport master (
        output i_start_calc, i_taps,
        input  o_sum, o_average, o_valid, o_busy, o_overrun
    );

    modport slave (
        input  i_start_calc, i_taps,
        output o_sum, o_average, o_valid, o_busy, o_overrun
    );
endinterface

// File: rtl/rolling_average_calc.sv
// Serial rolling average: sums one tap per cycle from a snapshot, result TOTAL_TAPS+2 edges after start.
// Starts while busy park in a single pending slot; a newer start overwrites it and pulses o_overrun.
module rolling_average_calc #(
    parameter int TOTAL_TAPS    = 8,
    parameter int BITS_PER_ELEM = 5,
    parameter int TOTAL_BITS    = 40
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rolling_average_calc_if.slave bus
);
    localparam int LOG2_TAPS = $clog2(TOTAL_TAPS);
    localparam int SUM_BITS  = BITS_PER_ELEM + LOG2_TAPS;
    localparam logic [LOG2_TAPS-1:0] LAST_IDX = LOG2_TAPS'(TOTAL_TAPS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                     state_q;
    logic [LOG2_TAPS-1:0]       idx_q;
    logic signed [SUM_BITS-1:0] acc_q;
    logic signed [SUM_BITS-1:0] sum_q;
    logic [TOTAL_BITS-1:0]      win_q;
    logic [TOTAL_BITS-1:0]      pend_win_q;
    logic [TOTAL_BITS-1:0]      pend_win_d;
    logic                       pend_q;
    logic                       pend_d;
    logic                       pub_q;
    logic                       valid_q;
    logic                       overrun_q;
    logic                       overrun_d;

    logic                       launch_new;
    logic                       launch_pend;
    logic                       capture;
    logic [BITS_PER_ELEM-1:0]   elem;
    logic signed [SUM_BITS-1:0] elem_ext;

    // A pending window launches only after the previous result has been published,
    // so results always leave in the order their windows were accepted.
    always_comb begin
        launch_new  = (state_q == IDLE) && !pend_q && bus.i_start_calc;
        launch_pend = (state_q == IDLE) && pend_q && !pub_q;
        capture     = bus.i_start_calc && !launch_new;
        overrun_d   = capture && pend_q && !launch_pend;
        pend_d      = capture || (pend_q && !launch_pend);
        pend_win_d  = capture ? bus.i_taps : pend_win_q;
        elem        = win_q[int'(idx_q)*BITS_PER_ELEM +: BITS_PER_ELEM];
        elem_ext    = {{LOG2_TAPS{elem[BITS_PER_ELEM-1]}}, elem};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            acc_q      <= '0;
            sum_q      <= '0;
            win_q      <= '0;
            pend_win_q <= '0;
            pend_q     <= 1'b0;
            pub_q      <= 1'b0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            pend_win_q <= pend_win_d;
            overrun_q  <= overrun_d;
            pub_q      <= (state_q == DONE);
            valid_q    <= pub_q;
            // acc_q is untouched between DONE and publication, even if a launch clears it this edge.
            if (pub_q) begin
                sum_q <= acc_q;
            end

            case (state_q)
                IDLE: begin
                    if (launch_new || launch_pend) begin
                        win_q   <= launch_pend ? pend_win_q : bus.i_taps;
                        acc_q   <= '0;
                        idx_q   <= '0;
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc_q <= acc_q + elem_ext;
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Floor division by TOTAL_TAPS is just the upper slice of the two's-complement sum.
    assign bus.o_sum     = sum_q;
    assign bus.o_average = sum_q[LOG2_TAPS +: BITS_PER_ELEM];
    assign bus.o_valid   = valid_q;
    assign bus.o_busy    = (state_q != IDLE);
    assign bus.o_overrun = overrun_q;
endmodule

// File: tb/tb_rolling_average_calc.sv
// Directed bench for rolling_average_calc with default parameters (8 taps of 5 bits).
// Edge 0 is the rising edge that samples the start pulse; outputs are sampled 1 time unit after each edge.
module tb_rolling_average_calc;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   e [8];
    int   lat;
    int   bc;
    int   ref_sum;
    int   got_lat;
    int   got_sum;
    int   got_avg;
    int   ovr_cnt;
    int   vld_cnt;
    int   vld_edge [2];
    int   vld_sum [2];
    int   ovr_edge;

    rolling_average_calc_if #(.TOTAL_TAPS(8), .BITS_PER_ELEM(5), .TOTAL_BITS(40)) bus ();

    rolling_average_calc #(.TOTAL_TAPS(8), .BITS_PER_ELEM(5), .TOTAL_BITS(40)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] pk(input int v [8]);
        logic [39:0] t;
        t = '0;
        for (int k = 0; k < 8; k++) t[k*5 +: 5] = 5'(v[k]);
        return t;
    endfunction

    task automatic set_all(input int v);
        for (int k = 0; k < 8; k++) e[k] = v;
    endtask

    // Start pulse sampled at the next rising edge; the tap bus is scrambled right after it.
    task automatic do_start(input logic [39:0] taps);
        @(negedge clk);
        bus.i_start_calc = 1'b1;
        bus.i_taps       = taps;
        @(posedge clk);
        #1;
        bus.i_start_calc = 1'b0;
        bus.i_taps       = {$urandom, 8'($urandom)};
    endtask

    task automatic wait_result(output int l, output int b);
        l = -1;
        b = bus.o_busy ? 1 : 0;
        for (int n = 1; n <= 15; n++) begin
            @(posedge clk);
            #1;
            if (bus.o_busy) b++;
            if (bus.o_valid) begin
                l = n;
                break;
            end
        end
    endtask

    task automatic run_window(input string tag, input int exp_sum, input int exp_avg);
        do_start(pk(e));
        wait_result(lat, bc);
        chk({tag, "_latency"}, lat, 10);
        chk({tag, "_sum"}, bus.o_sum, exp_sum);
        chk({tag, "_avg"}, bus.o_average, exp_avg);
        chk({tag, "_busy_cycles"}, bc, 9);
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        rst_n            = 1'b0;
        bus.i_start_calc = 1'b0;
        bus.i_taps       = '0;

        // Reset state
        #12;
        chk("rst_sum", bus.o_sum, 0);
        chk("rst_avg", bus.o_average, 0);
        chk("rst_valid", bus.o_valid, 0);
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_overrun", bus.o_overrun, 0);

        // Start on the very first edge after reset release: all threes
        set_all(3);
        @(negedge clk);
        rst_n            = 1'b1;
        bus.i_start_calc = 1'b1;
        bus.i_taps       = pk(e);
        @(posedge clk);
        #1;
        bus.i_start_calc = 1'b0;
        bus.i_taps       = '1;
        wait_result(lat, bc);
        chk("threes_latency", lat, 10);
        chk("threes_sum", bus.o_sum, 24);
        chk("threes_avg", bus.o_average, 3);
        chk("threes_busy_cycles", bc, 9);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_sum", bus.o_sum, 24);
        chk("hold_avg", bus.o_average, 3);
        chk("hold_valid_low", bus.o_valid, 0);

        set_all(-16);
        run_window("min", -128, -16);
        set_all(15);
        run_window("max", 120, 15);
        set_all(0);
        e[0] = -1;
        run_window("floor_neg1", -1, -1);
        set_all(15);
        e[7] = -16;
        run_window("mixed_89", 89, 11);
        e = '{-5, 2, -7, 0, 3, -1, -6, 4};
        run_window("floor_neg10", -10, -2);

        // A (all 1) at edge 0, B (all 2) at edge 3, C (all -2) at edge 5
        set_all(1);
        do_start(pk(e));
        vld_cnt  = 0;
        ovr_cnt  = 0;
        ovr_edge = -1;
        vld_edge = '{-1, -1};
        vld_sum  = '{0, 0};
        for (int ed = 1; ed <= 25; ed++) begin
            @(negedge clk);
            bus.i_start_calc = (ed == 3) || (ed == 5);
            set_all(ed == 3 ? 2 : -2);
            bus.i_taps = (ed == 3 || ed == 5) ? pk(e) : 40'h0_0000_0000;
            @(posedge clk);
            #1;
            bus.i_start_calc = 1'b0;
            if (bus.o_overrun) begin
                ovr_cnt++;
                ovr_edge = ed;
            end
            if (bus.o_valid) begin
                if (vld_cnt < 2) begin
                    vld_edge[vld_cnt] = ed;
                    vld_sum[vld_cnt]  = int'(bus.o_sum);
                end
                vld_cnt++;
            end
        end
        chk("ovr_pulses", ovr_cnt, 1);
        chk("ovr_edge", ovr_edge, 5);
        chk("ovr_valid_count", vld_cnt, 2);
        chk("ovr_a_edge", vld_edge[0], 10);
        chk("ovr_a_sum", vld_sum[0], 8);
        chk("ovr_c_edge", vld_edge[1], 21);
        chk("ovr_c_sum", vld_sum[1], -16);

        // Reset in the middle of a calculation
        set_all(7);
        do_start(pk(e));
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_sum", bus.o_sum, 0);
        chk("abort_avg", bus.o_average, 0);
        chk("abort_valid", bus.o_valid, 0);
        chk("abort_busy", bus.o_busy, 0);
        chk("abort_overrun", bus.o_overrun, 0);
        @(negedge clk);
        rst_n   = 1'b1;
        vld_cnt = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            if (bus.o_valid) vld_cnt++;
        end
        chk("abort_no_valid", vld_cnt, 0);
        e = '{7, -3, 5, 0, -8, 2, 1, 4};
        run_window("after_abort", 8, 1);

        // Back-to-back windows, one start every 12 edges
        ovr_cnt = 0;
        for (int w = 0; w < 50; w++) begin
            ref_sum = 0;
            for (int k = 0; k < 8; k++) begin
                e[k]    = int'($urandom_range(31)) - 16;
                ref_sum = ref_sum + e[k];
            end
            do_start(pk(e));
            got_lat = -1;
            got_sum = 0;
            got_avg = 0;
            for (int n = 1; n <= 11; n++) begin
                @(posedge clk);
                #1;
                if (bus.o_overrun) ovr_cnt++;
                if (bus.o_valid) begin
                    got_lat = n;
                    got_sum = int'(bus.o_sum);
                    got_avg = int'(bus.o_average);
                end
            end
            chk("bb_latency", got_lat, 10);
            chk("bb_sum", got_sum, ref_sum);
            chk("bb_avg", got_avg, ref_sum >>> 3);
        end
        chk("bb_no_overrun", ovr_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
